// File: rtl/i2s_adc_rx.sv
// I2S ADC receiver: synchronises codec BCLK/ADCLRCK/ADCDAT into clk and aligns to frames.
// Deserialises 16-bit left/right words and presents each stereo pair through valid/ready.
module i2s_adc_rx #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init_done,
    input  logic             AUD_BCLK,
    input  logic             AUD_ADCLRCK,
    input  logic             AUD_ADCDAT,
    output logic [WIDTH-1:0] out_left,
    output logic [WIDTH-1:0] out_right,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             frame_err
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        SKIP  = 3'd2,
        SHIFT = 3'd3,
        WAIT  = 3'd4
    } state_t;

    logic [1:0]       bclk_sync_r;
    logic [1:0]       lrck_sync_r;
    logic [1:0]       dat_sync_r;
    logic             bclk_prev_r;
    logic             bclk_rise_r;
    logic             lrck_smp_r;
    logic             dat_smp_r;
    logic             lrck_last_r;
    logic             lrck_edge_s;
    logic [WIDTH-1:0] word_s;

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-2:0] shreg_r;
    logic             chan_r;
    logic [WIDTH-1:0] hold_left_r;
    logic             have_left_r;

    // Pin synchronisers plus the edge register that aligns LRCK/DAT with bclk_rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_sync_r <= 2'b00;
            lrck_sync_r <= 2'b00;
            dat_sync_r  <= 2'b00;
            bclk_prev_r <= 1'b0;
            bclk_rise_r <= 1'b0;
            lrck_smp_r  <= 1'b0;
            dat_smp_r   <= 1'b0;
            lrck_last_r <= 1'b0;
        end else begin
            bclk_sync_r <= {bclk_sync_r[0], AUD_BCLK};
            lrck_sync_r <= {lrck_sync_r[0], AUD_ADCLRCK};
            dat_sync_r  <= {dat_sync_r[0], AUD_ADCDAT};
            bclk_prev_r <= bclk_sync_r[1];
            bclk_rise_r <= bclk_sync_r[1] & ~bclk_prev_r;
            lrck_smp_r  <= lrck_sync_r[1];
            dat_smp_r   <= dat_sync_r[1];
            if (bclk_rise_r) begin
                lrck_last_r <= lrck_smp_r;
            end
        end
    end

    // Edge detection and next-word assembly for the current bclk_rise cycle.
    always_comb begin
        lrck_edge_s = 1'b0;
        word_s      = {shreg_r, dat_smp_r};
        if (bclk_rise_r && (lrck_smp_r != lrck_last_r)) begin
            lrck_edge_s = 1'b1;
        end else begin
            lrck_edge_s = 1'b0;
        end
    end

    // Frame alignment, deserialisation and output handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            shreg_r     <= {(WIDTH-1){1'b0}};
            chan_r      <= 1'b0;
            hold_left_r <= {WIDTH{1'b0}};
            have_left_r <= 1'b0;
            out_left    <= {WIDTH{1'b0}};
            out_right   <= {WIDTH{1'b0}};
            out_valid   <= 1'b0;
            overrun     <= 1'b0;
            frame_err   <= 1'b0;
        end else if (!init_done) begin
            state_r     <= IDLE;
            out_valid   <= 1'b0;
            have_left_r <= 1'b0;
        end else begin
            // A completion later in this block overrides the acceptance clear.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    have_left_r <= 1'b0;
                    state_r     <= ALIGN;
                end
                ALIGN: begin
                    if (lrck_edge_s && !lrck_smp_r) begin
                        chan_r  <= 1'b0;
                        state_r <= SKIP;
                    end
                end
                // The delay bit is the bclk_rise that revealed the LRCK edge, so
                // SKIP only needs one clk to reset the counter.
                SKIP: begin
                    cnt_r   <= {CW{1'b0}};
                    state_r <= SHIFT;
                end
                SHIFT: begin
                    if (lrck_edge_s) begin
                        frame_err   <= 1'b1;
                        chan_r      <= lrck_smp_r;
                        have_left_r <= 1'b0;
                        state_r     <= SKIP;
                    end else if (bclk_rise_r) begin
                        shreg_r <= word_s[WIDTH-2:0];
                        cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                        if (cnt_r == CW'(WIDTH - 1)) begin
                            state_r <= WAIT;
                            if (!chan_r) begin
                                hold_left_r <= word_s;
                                have_left_r <= 1'b1;
                            end else begin
                                have_left_r <= 1'b0;
                                if (have_left_r) begin
                                    out_left  <= hold_left_r;
                                    out_right <= word_s;
                                    out_valid <= 1'b1;
                                    if (out_valid && !out_ready) begin
                                        overrun <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end
                WAIT: begin
                    if (lrck_edge_s) begin
                        chan_r  <= lrck_smp_r;
                        state_r <= SKIP;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_adc_rx.sv
// Bench for i2s_adc_rx: drives I2S frames at BCLK = clk/8 and scoreboards accepted pairs.
`timescale 1ns/1ps
module tb_i2s_adc_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        init_done;
    logic        AUD_BCLK;
    logic        AUD_ADCLRCK;
    logic        AUD_ADCDAT;
    logic [15:0] out_left;
    logic [15:0] out_right;
    logic        out_valid;
    logic        out_ready;
    logic        overrun;
    logic        frame_err;

    int          checks = 0;
    int          fails  = 0;
    logic [31:0] exp_q[$];

    i2s_adc_rx #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .init_done(init_done),
        .AUD_BCLK(AUD_BCLK), .AUD_ADCLRCK(AUD_ADCLRCK), .AUD_ADCDAT(AUD_ADCDAT),
        .out_left(out_left), .out_right(out_right), .out_valid(out_valid),
        .out_ready(out_ready), .overrun(overrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One I2S half-frame: slot 0 is the delay bit, slots 1..16 carry the word MSB first.
    task automatic send_half(input logic lr, input logic [15:0] w, input int slots);
        for (int i = 0; i < slots; i++) begin
            AUD_ADCLRCK = lr;
            if (i >= 1 && i <= 16) AUD_ADCDAT = w[16-i];
            else if (i == 0)       AUD_ADCDAT = 1'b1;
            else                   AUD_ADCDAT = 1'b0;
            #40 AUD_BCLK = 1'b1;
            #40 AUD_BCLK = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_half(1'b0, l, 20);
        send_half(1'b1, r, 20);
    endtask

    // Scoreboard monitor: every accepted pair must match the head of the queue.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_pair: got %h/%h expected none", out_left, out_right);
            end else begin
                check("pair", {out_left, out_right}, exp_q.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1; init_done = 1'b0; out_ready = 1'b1;
        AUD_BCLK = 1'b0; AUD_ADCLRCK = 1'b1; AUD_ADCDAT = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_left", {16'h0, out_left}, 32'h0);
        check("rst_right", {16'h0, out_right}, 32'h0);
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_overrun", {31'h0, overrun}, 32'h0);
        check("rst_frame_err", {31'h0, frame_err}, 32'h0);

        // Codec not yet configured: frames must be ignored.
        send_frame(16'hAAAA, 16'h5555);
        send_frame(16'h1234, 16'h4321);
        check("idle_valid", {31'h0, out_valid}, 32'h0);

        init_done = 1'b1;
        repeat (10) @(negedge clk);
        exp_q.push_back({16'hA5C3, 16'h0F0F});
        send_frame(16'hA5C3, 16'h0F0F);
        exp_q.push_back({16'hA5C3, 16'h0F0F});
        send_frame(16'hA5C3, 16'h0F0F);
        check("basic_overrun", {31'h0, overrun}, 32'h0);
        check("basic_frame_err", {31'h0, frame_err}, 32'h0);
        check("basic_queue", exp_q.size(), 32'h0);

        // Consumer stalls over two frames: second pair replaces the first.
        out_ready = 1'b0;
        send_frame(16'h1234, 16'h5678);
        check("stall_valid", {31'h0, out_valid}, 32'h1);
        check("stall_no_overrun", {31'h0, overrun}, 32'h0);
        send_frame(16'h9ABC, 16'hDEF0);
        check("ovr_valid", {31'h0, out_valid}, 32'h1);
        check("ovr_left", {16'h0, out_left}, {16'h0, 16'h9ABC});
        check("ovr_right", {16'h0, out_right}, {16'h0, 16'hDEF0});
        check("ovr_flag", {31'h0, overrun}, 32'h1);
        @(negedge clk);
        exp_q.push_back({16'h9ABC, 16'hDEF0});
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("ovr_sticky", {31'h0, overrun}, 32'h1);
        check("ovr_released", {31'h0, out_valid}, 32'h0);

        // Short left word: flagged, pair dropped, next frame good.
        send_half(1'b0, 16'hFFFF, 11);
        send_half(1'b1, 16'h1234, 20);
        check("ferr_flag", {31'h0, frame_err}, 32'h1);
        exp_q.push_back({16'h2468, 16'h1357});
        send_frame(16'h2468, 16'h1357);

        // init_done dropped mid-SHIFT with a pair pending.
        out_ready = 1'b0;
        send_frame(16'h1111, 16'h2222);
        check("init_pending", {31'h0, out_valid}, 32'h1);
        send_half(1'b0, 16'h3333, 8);
        @(negedge clk);
        init_done = 1'b0;
        @(negedge clk);
        check("init_drop_valid", {31'h0, out_valid}, 32'h0);
        check("init_keep_ferr", {31'h0, frame_err}, 32'h1);
        out_ready = 1'b1;
        init_done = 1'b1;
        send_half(1'b1, 16'hBEEF, 20);
        exp_q.push_back({16'h3C3C, 16'hC3C3});
        send_frame(16'h3C3C, 16'hC3C3);

        // Synchronous reset mid-word with a pair pending.
        out_ready = 1'b0;
        send_frame(16'h4444, 16'h5555);
        check("rst2_pending", {31'h0, out_valid}, 32'h1);
        send_half(1'b0, 16'h6666, 8);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst2_valid", {31'h0, out_valid}, 32'h0);
        check("rst2_left", {16'h0, out_left}, 32'h0);
        check("rst2_right", {16'h0, out_right}, 32'h0);
        check("rst2_overrun", {31'h0, overrun}, 32'h0);
        check("rst2_frame_err", {31'h0, frame_err}, 32'h0);
        out_ready = 1'b1;
        send_half(1'b1, 16'hBEEF, 20);
        exp_q.push_back({16'h6B2D, 16'h0001});
        send_frame(16'h6B2D, 16'h0001);

        repeat (20) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'h0);
        check("final_overrun", {31'h0, overrun}, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
